// File: rtl/jpeg_dht_pkg.sv
// Shared definitions for the JPEG DHT table store: loader state encoding,
// number of BITS entries per table, class codes and the table-index helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package jpeg_dht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNTS = 2'd1,
    ST_SYMS   = 2'd2,
    ST_DRAIN  = 2'd3
  } dht_state_t;

  localparam int NUM_BITS = 16;

  localparam logic [3:0] CLASS_DC = 4'd0;
  localparam logic [3:0] CLASS_AC = 4'd1;

  // Flat table slot for a {Tc,Th} pair.
  function automatic logic [31:0] tbl_index(input logic [31:0] tc,
                                            input logic [31:0] th,
                                            input logic [31:0] num_ids);
    return tc * num_ids + th;
  endfunction

endpackage

// File: rtl/jpeg_dht_sp_ram.sv
// Byte RAM with one write port and one registered read port.
// Latency: read data 1 cycle after re; rdata holds while re is low.
// Backpressure: none. Same-address write and read in one cycle returns the old word.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module jpeg_dht_sp_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jpeg_dht_ram.sv
// Huffman table store: parses DHT payload bytes (Tc/Th, 16 BITS, HUFFVAL) into per-table RAM slots.
// Latency: read port returns rd_cnt/rd_val/rd_loaded one cycle after rd_req; outputs hold otherwise.
// Backpressure: s_ready is high in every loader state once out of reset; bytes are never stalled.
// Ports: clk, rst (sync, active-low); s_valid/s_ready/s_data/s_last byte stream;
//   rd_req/rd_table/rd_len/rd_sym read request; rd_valid/rd_cnt/rd_val/rd_loaded read result;
//   tbl_loaded per-table flags; busy (loader not idle); err (sticky parse error).
// Option: define JPEG_DHT_RD_BYPASS_EN to make a read of the location written in the same
//   cycle return the new byte (and see a loaded flag being set that cycle).
module jpeg_dht_ram
  import jpeg_dht_pkg::*;
#(
  parameter int NUM_CLASSES = 2,
  parameter int NUM_IDS     = 2,
  parameter int SYM_DEPTH   = 256,
  parameter int TBL_W       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [7:0]                     s_data,
  input  logic                           s_last,
  input  logic                           rd_req,
  input  logic [TBL_W-1:0]               rd_table,
  input  logic [3:0]                     rd_len,
  input  logic [7:0]                     rd_sym,
  output logic                           rd_valid,
  output logic [7:0]                     rd_cnt,
  output logic [7:0]                     rd_val,
  output logic                           rd_loaded,
  output logic [NUM_CLASSES*NUM_IDS-1:0] tbl_loaded,
  output logic                           busy,
  output logic                           err
);

  localparam int NUM_TABLES = NUM_CLASSES * NUM_IDS;
  localparam int BITS_DEPTH = NUM_TABLES * NUM_BITS;
  localparam int HV_DEPTH   = NUM_TABLES * SYM_DEPTH;
  localparam int BITS_AW    = $clog2(BITS_DEPTH);
  localparam int HV_AW      = $clog2(HV_DEPTH);
  localparam int SYM_AW     = $clog2(SYM_DEPTH);

  dht_state_t            state;
  logic [TBL_W-1:0]      idx;
  logic [3:0]            cnt_idx;
  logic [11:0]           total;
  logic [SYM_AW-1:0]     sym_idx;

  logic                  accept;
  logic                  hdr_ok;
  logic [TBL_W-1:0]      hdr_idx;
  logic [NUM_TABLES-1:0] hdr_mask;
  logic [NUM_TABLES-1:0] idx_mask;
  logic [11:0]           total_nxt;
  logic                  last_cnt;
  logic                  last_sym;

  assign accept    = s_valid & s_ready;
  assign hdr_ok    = (32'(s_data[7:4]) < NUM_CLASSES) && (32'(s_data[3:0]) < NUM_IDS);
  assign hdr_idx   = TBL_W'(tbl_index(32'(s_data[7:4]), 32'(s_data[3:0]), NUM_IDS));
  assign hdr_mask  = NUM_TABLES'(1) << hdr_idx;
  assign idx_mask  = NUM_TABLES'(1) << idx;
  assign total_nxt = total + 12'(s_data);
  assign last_cnt  = (cnt_idx == 4'd15);
  assign last_sym  = (12'(sym_idx) == total - 12'd1);

  // Loader FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      tbl_loaded <= '0;
      idx        <= '0;
      cnt_idx    <= '0;
      total      <= '0;
      sym_idx    <= '0;
    end else begin
      s_ready <= 1'b1;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (!hdr_ok) begin
              err <= 1'b1;
              if (!s_last) begin
                state <= ST_DRAIN;
                busy  <= 1'b1;
              end
            end else if (s_last) begin
              // Header with no table body behind it.
              err <= 1'b1;
            end else begin
              idx        <= hdr_idx;
              tbl_loaded <= tbl_loaded & ~hdr_mask;
              cnt_idx    <= '0;
              total      <= '0;
              state      <= ST_COUNTS;
              busy       <= 1'b1;
            end
          end
          ST_COUNTS: begin
            total   <= total_nxt;
            cnt_idx <= cnt_idx + 4'd1;
            if (last_cnt) begin
              if (total_nxt > 12'(SYM_DEPTH)) begin
                err <= 1'b1;
                if (s_last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= ST_DRAIN;
                end
              end else if (total_nxt == 12'd0) begin
                // Empty table: no HUFFVAL bytes follow.
                tbl_loaded <= tbl_loaded | idx_mask;
                state      <= ST_IDLE;
                busy       <= 1'b0;
              end else if (s_last) begin
                err   <= 1'b1;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                sym_idx <= '0;
                state   <= ST_SYMS;
              end
            end else if (s_last) begin
              err   <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_SYMS: begin
            sym_idx <= sym_idx + SYM_AW'(1);
            if (last_sym) begin
              tbl_loaded <= tbl_loaded | idx_mask;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else if (s_last) begin
              err   <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (s_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // RAM write side
  logic               bits_we;
  logic               hv_we;
  logic [BITS_AW-1:0] bits_waddr;
  logic [HV_AW-1:0]   hv_waddr;

  assign bits_we    = accept && (state == ST_COUNTS);
  assign hv_we      = accept && (state == ST_SYMS);
  assign bits_waddr = BITS_AW'(32'(idx) * NUM_BITS + 32'(cnt_idx));
  assign hv_waddr   = HV_AW'(32'(idx) * SYM_DEPTH + 32'(sym_idx));

  // RAM read side; out-of-range tables read slot 0 and are masked to zero.
  logic                  rd_in_range;
  logic [NUM_TABLES-1:0] rd_mask;
  logic [BITS_AW-1:0]    bits_raddr;
  logic [HV_AW-1:0]      hv_raddr;
  logic [7:0]            bits_q;
  logic [7:0]            hv_q;
  logic                  rd_blank;

  assign rd_in_range = (32'(rd_table) < NUM_TABLES);
  assign rd_mask     = NUM_TABLES'(1) << rd_table;
  assign bits_raddr  = rd_in_range ? BITS_AW'(32'(rd_table) * NUM_BITS + 32'(rd_len)) : '0;
  assign hv_raddr    = rd_in_range ? HV_AW'(32'(rd_table) * SYM_DEPTH + 32'(rd_sym[SYM_AW-1:0])) : '0;

  jpeg_dht_sp_ram #(.DEPTH(BITS_DEPTH), .WIDTH(8)) u_bits_ram (
    .clk   (clk),
    .we    (bits_we),
    .waddr (bits_waddr),
    .wdata (s_data),
    .re    (rd_req),
    .raddr (bits_raddr),
    .rdata (bits_q)
  );

  jpeg_dht_sp_ram #(.DEPTH(HV_DEPTH), .WIDTH(8)) u_hv_ram (
    .clk   (clk),
    .we    (hv_we),
    .waddr (hv_waddr),
    .wdata (s_data),
    .re    (rd_req),
    .raddr (hv_raddr),
    .rdata (hv_q)
  );

`ifdef JPEG_DHT_RD_BYPASS_EN
  logic       set_loaded;
  logic       bits_hit;
  logic       hv_hit;
  logic       bits_byp;
  logic       hv_byp;
  logic [7:0] byp_dat;

  assign set_loaded = accept && (((state == ST_COUNTS) && last_cnt && (total_nxt == 12'd0)) ||
                                 ((state == ST_SYMS) && last_sym));
  assign bits_hit   = bits_we && rd_in_range && (bits_waddr == bits_raddr);
  assign hv_hit     = hv_we && rd_in_range && (hv_waddr == hv_raddr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid  <= 1'b0;
      rd_loaded <= 1'b0;
      rd_blank  <= 1'b1;
      bits_byp  <= 1'b0;
      hv_byp    <= 1'b0;
      byp_dat   <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_blank  <= !rd_in_range;
        rd_loaded <= (|(tbl_loaded & rd_mask)) || (set_loaded && (|(idx_mask & rd_mask)));
        bits_byp  <= bits_hit;
        hv_byp    <= hv_hit;
        byp_dat   <= s_data;
      end
    end
  end

  // Only one RAM is written per cycle, so a single captured byte serves both.
  assign rd_cnt = rd_blank ? 8'd0 : (bits_byp ? byp_dat : bits_q);
  assign rd_val = rd_blank ? 8'd0 : (hv_byp ? byp_dat : hv_q);
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid  <= 1'b0;
      rd_loaded <= 1'b0;
      rd_blank  <= 1'b1;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_blank  <= !rd_in_range;
        rd_loaded <= |(tbl_loaded & rd_mask);
      end
    end
  end

  // RAM read registers are not reset; rd_blank forces zero after reset and for bad tables.
  assign rd_cnt = rd_blank ? 8'd0 : bits_q;
  assign rd_val = rd_blank ? 8'd0 : hv_q;
`endif

endmodule

// File: tb/tb_jpeg_dht_ram.sv
// Directed bench for jpeg_dht_ram: table loads, back-to-back tables, parse errors,
// reset mid-load, out-of-range reads and same-cycle read/write behaviour.
module tb_jpeg_dht_ram;

  localparam int TBL_W = 3;

`ifdef JPEG_DHT_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [7:0]       s_data = 8'd0;
  logic             s_last = 1'b0;
  logic             rd_req = 1'b0;
  logic [TBL_W-1:0] rd_table = '0;
  logic [3:0]       rd_len = 4'd0;
  logic [7:0]       rd_sym = 8'd0;
  logic             rd_valid;
  logic [7:0]       rd_cnt;
  logic [7:0]       rd_val;
  logic             rd_loaded;
  logic [3:0]       tbl_loaded;
  logic             busy;
  logic             err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  jpeg_dht_ram #(.NUM_CLASSES(2), .NUM_IDS(2), .SYM_DEPTH(256), .TBL_W(TBL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .rd_req     (rd_req),
    .rd_table   (rd_table),
    .rd_len     (rd_len),
    .rd_sym     (rd_sym),
    .rd_valid   (rd_valid),
    .rd_cnt     (rd_cnt),
    .rd_val     (rd_val),
    .rd_loaded  (rd_loaded),
    .tbl_loaded (tbl_loaded),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One payload byte, optionally with a read request in the same cycle.
  task automatic xfer(input logic [7:0] d, input logic last, input logic rd,
                      input logic [TBL_W-1:0] t, input logic [3:0] l, input logic [7:0] sy);
    int n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) $display("FAIL s_ready_wait: s_ready=%b after %0d cycles, want 1", s_ready, n);
    else passes++;
    s_valid = 1'b1; s_data = d; s_last = last;
    rd_req = rd; rd_table = t; rd_len = l; rd_sym = sy;
    tick();
    s_valid = 1'b0; s_last = 1'b0; rd_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    xfer(d, last, 1'b0, '0, 4'd0, 8'd0);
  endtask

  task automatic send_bits(input logic [7:0] b [16]);
    for (int i = 0; i < 16; i++) send(b[i], 1'b0);
  endtask

  task automatic read(input logic [TBL_W-1:0] t, input logic [3:0] l, input logic [7:0] sy);
    rd_req = 1'b1; rd_table = t; rd_len = l; rd_sym = sy;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_ready, busy, err, rd_valid, rd_loaded, tbl_loaded, rd_cnt, rd_val} !== 25'd0)
      $display("FAIL reset_outputs: got rdy=%b busy=%b err=%b vld=%b ld=%b tl=%b cnt=%h val=%h, want all 0",
               s_ready, busy, err, rd_valid, rd_loaded, tbl_loaded, rd_cnt, rd_val);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready: s_ready=%b want 1", s_ready);
    else passes++;
  endtask

  task automatic test_load();
    logic [7:0] b [16] = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                           8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(8'h00, 1'b0);
    checks++;
    if (busy !== 1'b1) $display("FAIL load_busy: busy=%b want 1", busy);
    else passes++;
    send_bits(b);
    for (int i = 0; i < 12; i++) send(8'(i), i == 11);
    checks++;
    if (tbl_loaded !== 4'b0001) $display("FAIL load_flags: tbl_loaded=%b want 0001", tbl_loaded);
    else passes++;
    checks++;
    if ({err, busy} !== 2'b00) $display("FAIL load_err_busy: err=%b busy=%b want 0 0", err, busy);
    else passes++;
    read(3'd0, 4'd2, 8'd11);
    checks++;
    if ({rd_valid, rd_cnt, rd_val, rd_loaded} !== {1'b1, 8'd5, 8'd11, 1'b1})
      $display("FAIL load_read: vld=%b cnt=%0d val=%0d ld=%b want 1 5 11 1", rd_valid, rd_cnt, rd_val, rd_loaded);
    else passes++;
    tick();
    checks++;
    if ({rd_valid, rd_cnt, rd_val} !== {1'b0, 8'd5, 8'd11})
      $display("FAIL load_hold: vld=%b cnt=%0d val=%0d want 0 5 11", rd_valid, rd_cnt, rd_val);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1 [16] = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] b2 [16] = '{8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(8'h10, 1'b0);
    send_bits(b1);
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    checks++;
    if ({busy, tbl_loaded} !== 5'b0_0101) $display("FAIL b2b_mid: busy=%b tl=%b want 0 0101", busy, tbl_loaded);
    else passes++;
    send(8'h11, 1'b0);
    send_bits(b2);
    send(8'hB0, 1'b0); send(8'hB1, 1'b0); send(8'hB2, 1'b1);
    checks++;
    if ({err, tbl_loaded} !== 5'b0_1101) $display("FAIL b2b_flags: err=%b tl=%b want 0 1101", err, tbl_loaded);
    else passes++;
    read(3'd2, 4'd1, 8'd2);
    checks++;
    if ({rd_cnt, rd_val, rd_loaded} !== {8'd2, 8'hA3, 1'b1})
      $display("FAIL b2b_read_t2: cnt=%0d val=%h ld=%b want 2 a3 1", rd_cnt, rd_val, rd_loaded);
    else passes++;
    read(3'd3, 4'd2, 8'd0);
    checks++;
    if ({rd_cnt, rd_val, rd_loaded} !== {8'd3, 8'hB0, 1'b1})
      $display("FAIL b2b_read_t3: cnt=%0d val=%h ld=%b want 3 b0 1", rd_cnt, rd_val, rd_loaded);
    else passes++;
  endtask

  task automatic test_bad_header();
    send(8'h25, 1'b0);
    checks++;
    if ({err, busy} !== 2'b11) $display("FAIL badhdr_err: err=%b busy=%b want 1 1", err, busy);
    else passes++;
    send(8'h00, 1'b0); send(8'h07, 1'b0); send(8'h01, 1'b1);
    checks++;
    if ({err, busy, tbl_loaded} !== 6'b10_1101)
      $display("FAIL badhdr_drain: err=%b busy=%b tl=%b want 1 0 1101", err, busy, tbl_loaded);
    else passes++;
    read(3'd0, 4'd0, 8'd0);
    checks++;
    if (rd_cnt !== 8'd0) $display("FAIL badhdr_dropped: cnt=%0d want 0", rd_cnt);
    else passes++;
  endtask

  task automatic test_read_range();
    read(3'd0, 4'd2, 8'd11);
    checks++;
    if ({rd_cnt, rd_val} !== {8'd5, 8'd11}) $display("FAIL range_pre: cnt=%0d val=%0d want 5 11", rd_cnt, rd_val);
    else passes++;
    read(3'd5, 4'd2, 8'd11);
    checks++;
    if ({rd_valid, rd_cnt, rd_val, rd_loaded} !== {1'b1, 8'd0, 8'd0, 1'b0})
      $display("FAIL range_oor: vld=%b cnt=%0d val=%0d ld=%b want 1 0 0 0", rd_valid, rd_cnt, rd_val, rd_loaded);
    else passes++;
  endtask

  task automatic test_full_table();
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) b[i] = 8'd16;
    do_reset();
    checks++;
    if ({err, tbl_loaded} !== 5'b0_0000) $display("FAIL full_reset: err=%b tl=%b want 0 0000", err, tbl_loaded);
    else passes++;
    send(8'h00, 1'b0);
    send_bits(b);
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, i == 255);
    checks++;
    if ({err, busy, tbl_loaded} !== 6'b00_0001)
      $display("FAIL full_flags: err=%b busy=%b tl=%b want 0 0 0001", err, busy, tbl_loaded);
    else passes++;
    read(3'd0, 4'd15, 8'd255);
    checks++;
    if ({rd_cnt, rd_val, rd_loaded} !== {8'd16, 8'hA5, 1'b1})
      $display("FAIL full_read: cnt=%0d val=%h ld=%b want 16 a5 1", rd_cnt, rd_val, rd_loaded);
    else passes++;
  endtask

  task automatic test_overflow();
    send(8'h01, 1'b0);
    for (int i = 0; i < 15; i++) send(8'd16, 1'b0);
    checks++;
    if ({err, busy} !== 2'b01) $display("FAIL ovf_pre: err=%b busy=%b want 0 1", err, busy);
    else passes++;
    send(8'd17, 1'b0);
    checks++;
    if ({err, busy, tbl_loaded} !== 6'b11_0001)
      $display("FAIL ovf_err: err=%b busy=%b tl=%b want 1 1 0001", err, busy, tbl_loaded);
    else passes++;
    send(8'h00, 1'b0); send(8'h11, 1'b1);
    checks++;
    if ({busy, tbl_loaded} !== 5'b0_0001) $display("FAIL ovf_drain: busy=%b tl=%b want 0 0001", busy, tbl_loaded);
    else passes++;
  endtask

  task automatic test_early_last_and_reset();
    logic [7:0] b1 [16] = '{8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] b2 [16] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_reset();
    send(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) send(8'd1, i == 7);
    checks++;
    if ({err, busy, tbl_loaded} !== 6'b10_0000)
      $display("FAIL early_last: err=%b busy=%b tl=%b want 1 0 0000", err, busy, tbl_loaded);
    else passes++;
    do_reset();
    send(8'h01, 1'b0);
    send_bits(b1);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    checks++;
    if (busy !== 1'b1) $display("FAIL midsyms_busy: busy=%b want 1", busy);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if ({s_ready, busy, err, rd_valid, rd_loaded, tbl_loaded, rd_cnt, rd_val} !== 25'd0)
      $display("FAIL midsyms_reset: rdy=%b busy=%b err=%b vld=%b ld=%b tl=%b cnt=%h val=%h want all 0",
               s_ready, busy, err, rd_valid, rd_loaded, tbl_loaded, rd_cnt, rd_val);
    else passes++;
    rst = 1'b1;
    tick();
    send(8'h01, 1'b0);
    send_bits(b2);
    send(8'h77, 1'b1);
    checks++;
    if ({err, busy, tbl_loaded} !== 6'b00_0010)
      $display("FAIL after_reset_load: err=%b busy=%b tl=%b want 0 0 0010", err, busy, tbl_loaded);
    else passes++;
    read(3'd1, 4'd0, 8'd0);
    checks++;
    if ({rd_cnt, rd_val} !== {8'd1, 8'h77}) $display("FAIL after_reset_read: cnt=%0d val=%h want 1 77", rd_cnt, rd_val);
    else passes++;
  endtask

  task automatic test_collision();
    logic [7:0] b [16] = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                           8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(8'h00, 1'b0);
    send_bits(b);
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    checks++;
    if (tbl_loaded !== 4'b0011) $display("FAIL coll_first: tl=%b want 0011", tbl_loaded);
    else passes++;
    send(8'h00, 1'b0);
    checks++;
    if (tbl_loaded !== 4'b0010) $display("FAIL coll_reload_flag: tl=%b want 0010", tbl_loaded);
    else passes++;
    // Reload BITS as {1,1,0,...}; read BITS[0][0] while it is being rewritten.
    xfer(8'd1, 1'b0, 1'b1, 3'd0, 4'd0, 8'd0);
    checks++;
    if (rd_cnt !== (BYP ? 8'd1 : 8'd2)) $display("FAIL coll_bits: cnt=%0d want %0d", rd_cnt, BYP ? 1 : 2);
    else passes++;
    send(8'd1, 1'b0);
    for (int i = 2; i < 16; i++) send(8'd0, 1'b0);
    xfer(8'h33, 1'b0, 1'b1, 3'd0, 4'd0, 8'd0);
    checks++;
    if ({rd_val, rd_loaded} !== {(BYP ? 8'h33 : 8'h11), 1'b0})
      $display("FAIL coll_sym0: val=%h ld=%b want %h 0", rd_val, rd_loaded, BYP ? 8'h33 : 8'h11);
    else passes++;
    xfer(8'h44, 1'b1, 1'b1, 3'd0, 4'd0, 8'd1);
    checks++;
    if ({rd_val, rd_loaded} !== {(BYP ? 8'h44 : 8'h22), BYP})
      $display("FAIL coll_sym1: val=%h ld=%b want %h %b", rd_val, rd_loaded, BYP ? 8'h44 : 8'h22, BYP);
    else passes++;
    read(3'd0, 4'd0, 8'd1);
    checks++;
    if ({rd_cnt, rd_val, rd_loaded, tbl_loaded} !== {8'd1, 8'h44, 1'b1, 4'b0011})
      $display("FAIL coll_after: cnt=%0d val=%h ld=%b tl=%b want 1 44 1 0011", rd_cnt, rd_val, rd_loaded, tbl_loaded);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_bad_header();
    test_read_range();
    test_full_table();
    test_overflow();
    test_early_last_and_reset();
    test_collision();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
